// File: rtl/i2s_rx_deserializer.sv
// I2S receiver on the bit clock: captures PKT_WIDTH bits per slot and issues
// one mono (or left-only) sample per stereo frame as a one-cycle strobe.
module i2s_rx_deserializer #(
  parameter int unsigned PKT_WIDTH = 16,
  parameter bit          MONO_MIX  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 lrck_i,
  input  logic                 sd_i,
  output logic [PKT_WIDTH-1:0] pkt_s_o,
  output logic                 pktValid_s_o,
  output logic                 frameErr_s_o
);

  localparam int unsigned CNT_W = $clog2(PKT_WIDTH + 1);

  typedef enum logic {SYNC, RUN} state_t;

  state_t               state, stateNext;
  logic                 lrckPrev;
  // Only the PKT_WIDTH-1 bits ahead of the completing bit are ever read; the
  // finished word is formed with the live sd_i.
  logic [PKT_WIDTH-2:0] shiftReg, shiftNext;
  logic [CNT_W-1:0]     bitCnt, bitCntNext;
  logic [PKT_WIDTH-1:0] leftWord, leftWordNext;
  logic                 leftOk, leftOkNext;
  logic [PKT_WIDTH-1:0] pktNext;
  logic                 pktValidNext, frameErrNext;

  logic                 lrckEdge, shiftEn, wordDone;
  logic [PKT_WIDTH-1:0] word;
  logic [PKT_WIDTH:0]   mixSum;

  assign lrckEdge = (lrck_i != lrckPrev);
  assign shiftEn  = (state == RUN) && (bitCnt < CNT_W'(PKT_WIDTH));
  assign wordDone = shiftEn && (bitCnt == CNT_W'(PKT_WIDTH - 1));
  assign word     = {shiftReg, sd_i};
  assign mixSum   = {leftWord[PKT_WIDTH-1], leftWord} + {word[PKT_WIDTH-1], word};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= SYNC;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (state == SYNC && lrckEdge) stateNext = RUN;
  end

  always_comb begin
    shiftNext    = shiftReg;
    bitCntNext   = bitCnt;
    leftWordNext = leftWord;
    leftOkNext   = leftOk;
    pktNext      = pkt_s_o;
    pktValidNext = 1'b0;
    frameErrNext = 1'b0;

    if (shiftEn) begin
      shiftNext  = word[PKT_WIDTH-2:0];
      bitCntNext = bitCnt + CNT_W'(1);
    end

    // lrckPrev still names the slot that owns the bit sampled this cycle.
    if (wordDone) begin
      if (!lrckPrev) begin
        leftWordNext = word;
        leftOkNext   = 1'b1;
        if (!MONO_MIX) begin
          pktNext      = word;
          pktValidNext = 1'b1;
        end
      end else if (MONO_MIX && leftOk) begin
        pktNext      = PKT_WIDTH'(mixSum >> 1);
        pktValidNext = 1'b1;
        leftOkNext   = 1'b0;
      end
    end

    if (lrckEdge) begin
      bitCntNext = '0;
      if (state == RUN && bitCnt < CNT_W'(PKT_WIDTH - 1)) begin
        frameErrNext = 1'b1;
        if (!lrckPrev) leftOkNext = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    lrckPrev <= lrck_i;
    if (!rst_n_i) begin
      shiftReg     <= '0;
      bitCnt       <= '0;
      leftWord     <= '0;
      leftOk       <= 1'b0;
      pkt_s_o      <= '0;
      pktValid_s_o <= 1'b0;
      frameErr_s_o <= 1'b0;
    end else begin
      shiftReg     <= shiftNext;
      bitCnt       <= bitCntNext;
      leftWord     <= leftWordNext;
      leftOk       <= leftOkNext;
      pkt_s_o      <= pktNext;
      pktValid_s_o <= pktValidNext;
      frameErr_s_o <= frameErrNext;
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Scoreboard bench: a slot-level stream drives a mono-mix and a left-only
// instance; expectations come from a per-slot model of the framing rules.
module tb_i2s_rx_deserializer;

  logic        clk = 1'b0;
  logic        rst_n, lrck, sd;
  logic [15:0] pktM, pktL;
  logic        vM, vL, eM, eL;

  always #5 clk = ~clk;

  i2s_rx_deserializer #(.PKT_WIDTH(16), .MONO_MIX(1'b1)) dutMix (
    .clk_i(clk), .rst_n_i(rst_n), .lrck_i(lrck), .sd_i(sd),
    .pkt_s_o(pktM), .pktValid_s_o(vM), .frameErr_s_o(eM));

  i2s_rx_deserializer #(.PKT_WIDTH(16), .MONO_MIX(1'b0)) dutLeft (
    .clk_i(clk), .rst_n_i(rst_n), .lrck_i(lrck), .sd_i(sd),
    .pkt_s_o(pktL), .pktValid_s_o(vL), .frameErr_s_o(eL));

  typedef struct {
    bit          lr;
    int          w;
    logic [15:0] data;
    int          rstOff;
    int          rstLen;
  } slot_t;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } exp_t;

  slot_t slots[$];
  int    edgeAt[$];
  exp_t  pktQM[$], pktQL[$], errQM[$], errQL[$];
  bit    lrArr[], sdArr[], rstArr[];
  int    total;
  int    drvIdx = -1;
  int    errors = 0;
  int    checks = 0;

  task automatic addSlot(input bit lr, input int w, input logic [15:0] d,
                         input int rOff = -1, input int rLen = 0);
    slots.push_back('{lr, w, d, rOff, rLen});
  endtask

  task automatic addFrame(input logic [15:0] l, input logic [15:0] r, input int w);
    addSlot(1'b0, w, l);
    addSlot(1'b1, w, r);
  endtask

  task automatic buildStream();
    int t = 0;
    foreach (slots[i]) begin
      edgeAt.push_back(t);
      t += slots[i].w;
    end
    total  = t + 8;
    lrArr  = new[total];
    sdArr  = new[total];
    rstArr = new[total];
    for (int k = 0; k < total; k++) begin
      lrArr[k]  = !slots[slots.size()-1].lr;
      sdArr[k]  = 1'($urandom);
      rstArr[k] = 1'b1;
    end
    foreach (slots[i]) begin
      for (int k = 0; k < slots[i].w; k++) begin
        lrArr[edgeAt[i] + k] = slots[i].lr;
        // data lags LRCK by one bit clock
        if (k < 16) sdArr[edgeAt[i] + 1 + k] = slots[i].data[15 - k];
      end
      if (slots[i].rstOff >= 0)
        for (int k = 0; k < slots[i].rstLen; k++) rstArr[edgeAt[i] + slots[i].rstOff + k] = 1'b0;
    end
  endtask

  // Slot-level model: a slot counts only if it began on a real LRCK change and
  // no reset touched it; a reset anywhere also forgets a pending left word.
  task automatic buildExpect();
    bit          lOk = 1'b0;
    logic [15:0] lWord = '0;
    int          cPrev = -1;
    for (int s = 1; s < slots.size(); s++) begin
      int es = edgeAt[s];
      int ws = slots[s].w;
      int c  = es + ((ws >= 16) ? 16 : ws);
      int k0 = (es < cPrev + 1) ? es : cPrev + 1;
      bit rAny = 1'b0;
      bit rIn  = 1'b0;
      for (int k = k0; k <= c; k++)
        if (!rstArr[k]) begin
          if (k > cPrev) rAny = 1'b1;
          if (k >= es)   rIn  = 1'b1;
        end
      cPrev = c;
      if (rAny) lOk = 1'b0;
      if (rIn) continue;
      if (ws < 16) begin
        errQM.push_back('{c, 16'h0});
        errQL.push_back('{c, 16'h0});
        if (!slots[s].lr) lOk = 1'b0;
        continue;
      end
      if (!slots[s].lr) begin
        lOk   = 1'b1;
        lWord = slots[s].data;
        pktQL.push_back('{c, slots[s].data});
      end else if (lOk) begin
        int sum = int'($signed(lWord)) + int'($signed(slots[s].data));
        pktQM.push_back('{c, 16'(sum >>> 1)});
        lOk = 1'b0;
      end
    end
  endtask

  task automatic checkDut(input bit mix, input logic v, input logic [15:0] p, input logic fe);
    exp_t x;
    string nm = mix ? "mix" : "left";
    if (!rstArr[drvIdx]) begin
      checks++;
      if (v !== 1'b0 || fe !== 1'b0 || p !== 16'h0) begin
        errors++;
        $display("FAIL reset_outputs %s cyc=%0d got v=%b err=%b pkt=%h want v=0 err=0 pkt=0000",
                 nm, drvIdx, v, fe, p);
      end
    end
    if (v === 1'b1) begin
      checks++;
      if ((mix ? pktQM.size() : pktQL.size()) == 0) begin
        errors++;
        $display("FAIL pkt_unexpected %s cyc=%0d got strobe pkt=%h want none", nm, drvIdx, p);
      end else begin
        x = mix ? pktQM.pop_front() : pktQL.pop_front();
        if (x.cyc != drvIdx || p !== x.val) begin
          errors++;
          $display("FAIL pkt %s got cyc=%0d pkt=%h want cyc=%0d pkt=%h", nm, drvIdx, p, x.cyc, x.val);
        end
      end
    end
    if (fe === 1'b1) begin
      checks++;
      if ((mix ? errQM.size() : errQL.size()) == 0) begin
        errors++;
        $display("FAIL frameerr_unexpected %s cyc=%0d got strobe want none", nm, drvIdx);
      end else begin
        x = mix ? errQM.pop_front() : errQL.pop_front();
        if (x.cyc != drvIdx) begin
          errors++;
          $display("FAIL frameerr %s got cyc=%0d want cyc=%0d", nm, drvIdx, x.cyc);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (drvIdx >= 0) begin
      checkDut(1'b1, vM, pktM, eM);
      checkDut(1'b0, vL, pktL, eL);
    end
  end

  task automatic checkDrained(input string nm, input int left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL drained_%s got %0d outstanding want 0", nm, left);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    lrck  = 1'b0;
    sd    = 1'b0;

    addSlot(1'b0, 16, 16'h1234, 0, 3);
    addSlot(1'b1, 16, 16'h5678);
    repeat (2) addFrame(16'h1234, 16'h5678, 16);
    addFrame(16'h7FFF, 16'h7FFF, 16);
    addFrame(16'h8000, 16'h8000, 16);
    addFrame(16'hFFFF, 16'h0000, 16);
    addFrame(16'hA5C3, 16'h0F0F, 32);
    addSlot(1'b0, 10, 16'hDEAD);
    addSlot(1'b1, 16, 16'h4321);
    addFrame(16'h1000, 16'h3000, 16);
    addSlot(1'b0, 16, 16'h1111);
    addSlot(1'b1, 16, 16'h2222, 6, 2);
    addFrame(16'h0100, 16'h0300, 16);
    addFrame(16'hFF00, 16'h0F00, 16);
    for (int f = 0; f < 1000; f++) begin
      int w = ($urandom_range(3, 0) == 0) ? int'($urandom_range(24, 17)) : 16;
      addFrame(16'($urandom), 16'($urandom), w);
    end

    buildStream();
    buildExpect();

    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      lrck   = lrArr[k];
      sd     = sdArr[k];
      rst_n  = rstArr[k];
      drvIdx = k;
    end
    repeat (3) @(negedge clk);

    checkDrained("pkt_mix", pktQM.size());
    checkDrained("pkt_left", pktQL.size());
    checkDrained("err_mix", errQM.size());
    checkDrained("err_left", errQL.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
